// File: rtl/nes_pkg.sv
// Shared NES pad definitions: FSM states and button bit positions.
// Used by the device-side emulator and the host-side reader.
package nes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } nes_state_t;

  localparam int unsigned NES_NUM_BUTTONS = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Wire level is active-low; the reader inverts back to 1=pressed.
  function automatic logic [NES_NUM_BUTTONS-1:0] nes_wire_to_buttons(
    input logic [NES_NUM_BUTTONS-1:0] wire_bits
  );
    return ~wire_bits;
  endfunction

endpackage

// File: rtl/nes_sync_edge.sv
// Multi-flop synchronizer for an async host line.
// Emits an aligned level plus registered rise/fall pulses.
module nes_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic lvl_q, lvl_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    lvl_d  = sync_out;
    rise_d = sync_out & ~lvl_q;
    fall_d = ~sync_out & lvl_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/nes_controller_emulator.sv
// Device-side NES pad: latches buttons on host latch and
// shifts them out active-low on each host clock rising edge.
module nes_controller_emulator
  import nes_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk_10MHz,
  input  logic       reset,
  input  logic       NESLatch,
  input  logic       NESClk,
  input  logic [7:0] buttons,
  output logic       NESdata,
  output logic [3:0] bitCount,
  output logic       frameDone,
  output logic [1:0] stateWire
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_rise, clk_fall, clk_lvl_unused;

  nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk_10MHz),
    .rst_n (reset),
    .din   (NESLatch),
    .level (latch_lvl),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk_10MHz),
    .rst_n (reset),
    .din   (NESClk),
    .level (clk_lvl_unused),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  nes_state_t state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] bit_q, bit_d;
  logic       done_q, done_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic active, any_edge, timeout;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    done_d   = 1'b0;
    tmr_d    = '0;
    active   = (state_q == SHIFT) || (state_q == DONE);
    any_edge = latch_rise | latch_fall | clk_rise | clk_fall;
    timeout  = active && !any_edge && (tmr_q == TO_LAST);

    if (active && !any_edge) begin
      tmr_d = (tmr_q == TO_MAX) ? tmr_q : tmr_q + 1'b1;
    end

    // Latch level has priority over everything, including a same-cycle shift.
    if (latch_lvl) begin
      state_d = LATCH;
      shreg_d = ~buttons;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        LATCH: begin
          state_d = SHIFT;
        end
        SHIFT: begin
          if (timeout) begin
            state_d = IDLE;
            shreg_d = 8'hFF;
            bit_d   = '0;
          end else if (clk_rise) begin
            shreg_d = {1'b1, shreg_q[7:1]};
            bit_d   = bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (timeout) begin
            state_d = IDLE;
            shreg_d = 8'hFF;
            bit_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_10MHz) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= 8'hFF;
      bit_q   <= '0;
      done_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      tmr_q   <= tmr_d;
    end
  end

  assign NESdata   = shreg_q[0] | (bit_q == 4'd8);
  assign bitCount  = bit_q;
  assign frameDone = done_q;
  assign stateWire = state_q;

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Randomized bench for nes_controller_emulator against a
// frame-level reference model of the NES pad protocol.
`timescale 1ns/1ps
module tb_nes_controller_emulator;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       NESLatch;
  logic       NESClk;
  logic [7:0] buttons;
  logic       NESdata;
  logic [3:0] bitCount;
  logic       frameDone;
  logic [1:0] stateWire;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  nes_controller_emulator #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_10MHz (clk),
    .reset     (reset),
    .NESLatch  (NESLatch),
    .NESClk    (NESClk),
    .buttons   (buttons),
    .NESdata   (NESdata),
    .bitCount  (bitCount),
    .frameDone (frameDone),
    .stateWire (stateWire)
  );

  always #50 clk = ~clk;

  always @(negedge clk) if (frameDone === 1'b1) n_done++;

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Host raises latch, lets buttons wander, then settles on btn.
  task automatic latch_pulse(input logic [7:0] btn);
    buttons  = 8'($urandom);
    NESLatch = 1'b1;
    tick($urandom_range(3, 8));
    buttons = btn;
    tick(6);
    check("latch_state", stateWire, 1);
    check("latch_data", NESdata, !btn[0]);
    check("latch_cnt", bitCount, 0);
    NESLatch = 1'b0;
  endtask

  task automatic frame(input logic [7:0] btn, input int nclk,
                       input bit mid_chg, input logic [7:0] alt,
                       input bit to_idle);
    int h;
    int d0;
    logic [7:0] rd;
    h  = $urandom_range(6, 15);
    d0 = n_done;
    rd = '0;
    latch_pulse(btn);
    tick(h);
    check("shift_state", stateWire, 2);
    for (int i = 1; i <= nclk; i++) begin
      if (i <= 8) rd[i-1] = !NESdata;
      if (mid_chg && i == 4) buttons = alt;
      NESClk = 1'b0;
      tick(h);
      NESClk = 1'b1;
      tick(h);
      check("bitcount", bitCount, (i < 8) ? i : 8);
      check("nesdata", NESdata, (i < 8) ? !btn[i] : 1'b1);
    end
    if (nclk >= 8) check("readback", rd, btn);
    check("framedone", n_done - d0, (nclk >= 8) ? 1 : 0);
    if (to_idle) begin
      tick(TO + 3 - h);
      check("pre_timeout", stateWire, (nclk >= 8) ? 3 : 2);
      tick(1);
      check("timeout_state", stateWire, 0);
      check("timeout_cnt", bitCount, 0);
      check("timeout_data", NESdata, 1);
    end
  endtask

  initial begin
    logic [7:0] nb;
    int d0;
    reset    = 1'b0;
    NESLatch = 1'b0;
    NESClk   = 1'b1;
    buttons  = 8'h00;
    tick(3);
    check("rst_state", stateWire, 0);
    check("rst_data", NESdata, 1);
    check("rst_cnt", bitCount, 0);
    check("rst_done", frameDone, 0);
    reset = 1'b1;
    tick(10);
    check("idle_after_rst", stateWire, 0);

    frame(8'h01, 8, 1'b0, 8'h00, 1'b1);
    frame(8'hA5, 8, 1'b1, 8'h3C, 1'b1);

    frame(8'h5E, 3, 1'b0, 8'h00, 1'b0);
    frame(8'hC3, 8, 1'b0, 8'h00, 1'b1);

    frame(8'h96, 12, 1'b0, 8'h00, 1'b1);

    latch_pulse(8'h77);
    tick(TO + 3);
    check("stall_shift", stateWire, 2);
    tick(1);
    check("stall_idle", stateWire, 0);
    check("stall_cnt", bitCount, 0);
    check("stall_data", NESdata, 1);

    frame(8'h3B, 4, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("midrst_state", stateWire, 0);
    check("midrst_cnt", bitCount, 0);
    check("midrst_data", NESdata, 1);
    tick(10);

    frame(8'hE8, 7, 1'b0, 8'h00, 1'b0);
    d0 = n_done;
    nb = 8'h4D;
    NESClk = 1'b0;
    tick(8);
    buttons  = nb;
    NESLatch = 1'b1;
    NESClk   = 1'b1;
    tick(8);
    check("simul_state", stateWire, 1);
    check("simul_cnt", bitCount, 0);
    check("simul_data", NESdata, !nb[0]);
    check("simul_nodone", n_done - d0, 0);
    NESLatch = 1'b0;
    tick(8);

    for (int r = 0; r < 6; r++) begin
      frame(8'($urandom), $urandom_range(8, 12), 1'b1,
            8'($urandom), (r % 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
